shared_mem_responder: RTL and testbench

SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

---
 rtl/gpu_mem_pkg.sv | 23 ++
 rtl/shared_mem_responder_if.sv | 36 +++
 rtl/sm_ram.sv | 31 +++
 rtl/shared_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_shared_mem_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the shared-memory responder slice.
//   - Default geometry: core count, byte-address width, data width.
//   - Responder FSM state encoding.
//   - Round-robin pointer advance helper.
package gpu_mem_pkg;

    localparam int N_CORES_DEF = 4;
    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Advance a round-robin index, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/shared_mem_responder_if.sv
// Core-side bus of the shared-memory responder.
//   mem_req_ld / mem_req_st : per-core level requests, held until acknowledged
//   addr_in / wdata_in      : per-core address and store data, core k at slice k
//   val_data                : one-hot single-cycle acknowledge
//   mem_dat                 : load data broadcast to all cores
//   busy                    : responder not idle
//   conflict                : granted core asked for load and store together
// Modports: master = core cluster side, slave = responder side.
interface shared_mem_responder_if
    import gpu_mem_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) ();

    logic [N_CORES-1:0]        mem_req_ld;
    logic [N_CORES-1:0]        mem_req_st;
    logic [N_CORES*ADDR_W-1:0] addr_in;
    logic [N_CORES*DATA_W-1:0] wdata_in;
    logic [N_CORES-1:0]        val_data;
    logic [DATA_W-1:0]         mem_dat;
    logic                      busy;
    logic                      conflict;

    modport master (
        output mem_req_ld, mem_req_st, addr_in, wdata_in,
        input  val_data, mem_dat, busy, conflict
    );

    modport slave (
        input  mem_req_ld, mem_req_st, addr_in, wdata_in,
        output val_data, mem_dat, busy, conflict
    );

endinterface

// File: rtl/sm_ram.sv
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, one-cycle registered read.
// A write and a read to the same address in one cycle return the old contents.
// Contents are deliberately not reset.
//   clk   : clock
//   we    : write enable
//   addr  : byte address
//   wdata : write data
//   rdata : read data, valid the cycle after addr is presented
module sm_ram
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/shared_mem_responder.sv
// Shared-memory responder: arbitrates load/store requests from N_CORES cores
// round-robin and serves one transaction at a time from a shared RAM.
//   clk      : clock, all logic on posedge
//   reset    : synchronous, active-high
//   bus      : core-side bus (slave modport), see shared_mem_responder_if
//   ld_count : loads acknowledged, saturating (SHARED_MEM_STATS_EN only)
//   st_count : stores acknowledged, saturating (SHARED_MEM_STATS_EN only)
// Build option: define SHARED_MEM_STATS_EN to add the ld_count/st_count counters.
//
// state  | meaning
// IDLE   | arbitrate pending cores, latch the winner's addr/data/op
// ACCESS | single RAM access (write for store, read for load)
// RESP   | acknowledge the granted core, drive load data
// HOLD   | one-cycle gap while the served core drops its request
module shared_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_mem_responder_if.slave bus
`ifdef SHARED_MEM_STATS_EN
    ,
    output logic [15:0]          ld_count,
    output logic [15:0]          st_count
`endif
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    state_t             state;
    state_t             state_nxt;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               op_st_q;
    logic               op_conf_q;
    logic [N_CORES-1:0] mask;

    logic [N_CORES-1:0] pending;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;

    logic [ADDR_W-1:0]  addr_arr  [N_CORES];
    logic [DATA_W-1:0]  wdata_arr [N_CORES];

    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;

    logic [N_CORES-1:0] val_data;
    logic [DATA_W-1:0]  mem_dat;

    for (genvar k = 0; k < N_CORES; k++) begin : g_slice
        assign addr_arr[k]  = bus.addr_in[k*ADDR_W +: ADDR_W];
        assign wdata_arr[k] = bus.wdata_in[k*DATA_W +: DATA_W];
    end

    assign pending = (bus.mem_req_ld | bus.mem_req_st) & ~mask;

    // First pending core at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_CORES);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_st_q   <= 1'b0;
            op_conf_q <= 1'b0;
            mask      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_idx   <= pick;
                        addr_q    <= addr_arr[pick];
                        wdata_q   <= wdata_arr[pick];
                        // Store wins when both ops are requested.
                        op_st_q   <= bus.mem_req_st[pick];
                        op_conf_q <= bus.mem_req_ld[pick] & bus.mem_req_st[pick];
                    end
                end
                RESP: begin
                    rr_ptr <= IDX_W'(rr_next(int'(gnt_idx), N_CORES));
                    mask   <= N_CORES'(1) << gnt_idx;
                end
                HOLD: begin
                    mask <= '0;
                end
                default: ;
            endcase
        end
    end

    // Gating with reset keeps a store aborted in ACCESS from reaching the RAM.
    assign ram_we = (state == ACCESS) && op_st_q && !reset;

    sm_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        val_data = '0;
        mem_dat  = '0;
        if (state == RESP) begin
            val_data[gnt_idx] = 1'b1;
            if (!op_st_q) begin
                mem_dat = ram_rdata;
            end
        end
    end

    assign bus.val_data = val_data;
    assign bus.mem_dat  = mem_dat;
    assign bus.busy     = (state != IDLE);
    assign bus.conflict = (state == ACCESS) && op_conf_q;

`ifdef SHARED_MEM_STATS_EN
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else if (state == RESP) begin
            if (op_st_q) begin
                if (st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
            end else begin
                if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
            end
        end
    end

    assign ld_count = ld_cnt;
    assign st_count = st_cnt;
`endif

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed bench for shared_mem_responder with an acknowledge scoreboard.
module tb_shared_mem_responder;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    shared_mem_responder_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SHARED_MEM_STATS_EN
    logic [15:0] ld_count;
    logic [15:0] st_count;
`endif

    shared_mem_responder #(
        .N_CORES (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SHARED_MEM_STATS_EN
        ,
        .ld_count (ld_count),
        .st_count (st_count)
`endif
    );

    typedef struct {
        int          core;
        logic [DW-1:0] data;
        bit          conf;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int core, input bit ld, input bit st,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mem_req_ld[core]         = ld;
        bus.mem_req_st[core]         = st;
        bus.addr_in[core*AW +: AW]   = a;
        bus.wdata_in[core*DW +: DW]  = d;
    endtask

    task automatic drop(input int core);
        bus.mem_req_ld[core] = 1'b0;
        bus.mem_req_st[core] = 1'b0;
    endtask

    task automatic expect_ack(input int core, input logic [DW-1:0] data, input bit conf);
        sb_t e;
        e.core = core;
        e.data = data;
        e.conf = conf;
        sb.push_back(e);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_val_data", 32'(bus.val_data), 32'd0);
        check("rst_mem_dat", 32'(bus.mem_dat), 32'd0);
        check("rst_conflict", 32'(bus.conflict), 32'd0);
        reset = 1'b0;
    endtask

    // Waits (bounded) for the next acknowledge and checks it against the scoreboard head.
    task automatic wait_ack(input string tag, input int exp_lat, input bit do_drop);
        sb_t  e;
        int   n;
        bit   got;
        bit   conf_seen;
        n = 0;
        got = 1'b0;
        conf_seen = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (bus.conflict) conf_seen = 1'b1;
            if (bus.val_data != '0) got = 1'b1;
        end
        check({tag, "_acked"}, 32'(got), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (got) begin
                check({tag, "_latency"}, 32'(n), 32'(exp_lat));
                check({tag, "_val_data"}, 32'(bus.val_data), 32'(1) << e.core);
                check({tag, "_mem_dat"}, 32'(bus.mem_dat), 32'(e.data));
                check({tag, "_conflict"}, 32'(conf_seen), 32'(e.conf));
                if (do_drop) drop(e.core);
            end
        end
    endtask

    // Acknowledge must be one-hot and only while busy.
    always @(negedge clk) begin
        if (!reset) begin
            check("val_data_onehot", 32'($onehot0(bus.val_data)), 32'd1);
            if (bus.val_data != '0) check("ack_while_busy", 32'(bus.busy), 32'd1);
        end
    end

    initial begin
        bus.mem_req_ld = '0;
        bus.mem_req_st = '0;
        bus.addr_in    = '0;
        bus.wdata_in   = '0;

        @(negedge clk);
        do_reset();

        // Core 1 stores then loads 0x123.
        drive(1, 1'b0, 1'b1, 12'h123, 8'hA5);
        expect_ack(1, 8'h00, 1'b0);
        wait_ack("c1_store", 2, 1'b1);
        settle();
        drive(1, 1'b1, 1'b0, 12'h123, 8'h00);
        expect_ack(1, 8'hA5, 1'b0);
        wait_ack("c1_load", 2, 1'b1);
        settle();

        // Each core writes its own pattern.
        for (int k = 0; k < N; k++) begin
            drive(k, 1'b0, 1'b1, 12'h040 + 12'(k), 8'h40 + 8'(k));
            expect_ack(k, 8'h00, 1'b0);
            wait_ack("pre_store", 2, 1'b1);
            settle();
        end

        // Reset keeps RAM and returns rr_ptr to 0; all cores load together.
        do_reset();
        for (int k = 0; k < N; k++) begin
            drive(k, 1'b1, 1'b0, 12'h040 + 12'(k), 8'h00);
            expect_ack(k, 8'h40 + 8'(k), 1'b0);
        end
        wait_ack("rr_c0", 2, 1'b1);
        wait_ack("rr_c1", 4, 1'b1);
        wait_ack("rr_c2", 4, 1'b1);
        wait_ack("rr_c3", 4, 1'b1);
        settle();

        // Core 2 keeps its request up through the cycle after the acknowledge.
        drive(2, 1'b1, 1'b0, 12'h123, 8'h00);
        expect_ack(2, 8'hA5, 1'b0);
        wait_ack("hold_c2", 2, 1'b0);
        @(negedge clk);
        check("hold_no_reack", 32'(bus.val_data), 32'd0);
        drop(2);
        @(negedge clk);
        check("hold_idle_busy", 32'(bus.busy), 32'd0);

        // rr_ptr now 3: core 3 beats core 0.
        drive(0, 1'b1, 1'b0, 12'h040, 8'h00);
        drive(3, 1'b1, 1'b0, 12'h043, 8'h00);
        expect_ack(3, 8'h43, 1'b0);
        expect_ack(0, 8'h40, 1'b0);
        wait_ack("wrap_c3", 2, 1'b1);
        wait_ack("wrap_c0", 4, 1'b1);
        settle();

        // Core 3 requests load and store together: store wins.
        drive(3, 1'b1, 1'b1, 12'h010, 8'h3C);
        expect_ack(3, 8'h00, 1'b1);
        wait_ack("conf_c3", 2, 1'b1);
        settle();
        drive(0, 1'b1, 1'b0, 12'h010, 8'h00);
        expect_ack(0, 8'h3C, 1'b0);
        wait_ack("conf_load", 2, 1'b1);
        settle();

        // Address/data changed after grant are ignored.
        drive(0, 1'b1, 1'b0, 12'h123, 8'h00);
        expect_ack(0, 8'hA5, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 12'h010, 8'h00);
        wait_ack("latch_ld", 1, 1'b1);
        settle();
        drive(1, 1'b0, 1'b1, 12'h300, 8'h5A);
        expect_ack(1, 8'h00, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 12'h301, 8'hFF);
        wait_ack("latch_st", 1, 1'b1);
        settle();
        drive(2, 1'b1, 1'b0, 12'h300, 8'h00);
        expect_ack(2, 8'h5A, 1'b0);
        wait_ack("latch_rd", 2, 1'b1);
        settle();

        // Reset during ACCESS of a store aborts it before the write.
        drive(0, 1'b0, 1'b1, 12'h200, 8'h11);
        expect_ack(0, 8'h00, 1'b0);
        wait_ack("abort_pre", 2, 1'b1);
        settle();
        drive(1, 1'b0, 1'b1, 12'h200, 8'h77);
        @(negedge clk);
        check("abort_in_access", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        drop(1);
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_val_data", 32'(bus.val_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", 32'(bus.val_data), 32'd0);
        end
        drive(1, 1'b1, 1'b0, 12'h200, 8'h00);
        expect_ack(1, 8'h11, 1'b0);
        wait_ack("abort_rd", 2, 1'b1);
        settle();

        // Two stores and two more loads (three loads since reset).
        drive(2, 1'b0, 1'b1, 12'h201, 8'h99);
        expect_ack(2, 8'h00, 1'b0);
        wait_ack("mix_st0", 2, 1'b1);
        settle();
        drive(3, 1'b0, 1'b1, 12'h202, 8'h98);
        expect_ack(3, 8'h00, 1'b0);
        wait_ack("mix_st1", 2, 1'b1);
        settle();
        drive(0, 1'b1, 1'b0, 12'h201, 8'h00);
        expect_ack(0, 8'h99, 1'b0);
        wait_ack("mix_ld0", 2, 1'b1);
        settle();
        drive(1, 1'b1, 1'b0, 12'h202, 8'h00);
        expect_ack(1, 8'h98, 1'b0);
        wait_ack("mix_ld1", 2, 1'b1);
        settle();
`ifdef SHARED_MEM_STATS_EN
        check("ld_count", 32'(ld_count), 32'd3);
        check("st_count", 32'(st_count), 32'd2);
`endif
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        check("end_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
